// File: rtl/universal_register_n_if.sv
// Command/status bundle for universal_register_n.
// Optional parity signal present when UREG_PARITY_EN is defined.
interface universal_register_n_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             cl;
    logic             ld;
    logic [WIDTH-1:0] in;
    logic             inc;
    logic             dec;
    logic             sr;
    logic             sl;
    logic             ir;
    logic             il;
    logic             rot;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             carry;
    logic             zero;
`ifdef UREG_PARITY_EN
    logic             parity;

    modport master (
        output cl, ld, in, inc, dec, sr, sl, ir, il, rot, amt,
        input  out, busy, carry, zero, parity
    );
    modport slave (
        input  cl, ld, in, inc, dec, sr, sl, ir, il, rot, amt,
        output out, busy, carry, zero, parity
    );
`else
    modport master (
        output cl, ld, in, inc, dec, sr, sl, ir, il, rot, amt,
        input  out, busy, carry, zero
    );
    modport slave (
        input  cl, ld, in, inc, dec, sr, sl, ir, il, rot, amt,
        output out, busy, carry, zero
    );
`endif
endinterface

// File: rtl/universal_register_n.sv
// WIDTH-bit clear/load/inc/dec/shift/rotate register with multi-cycle shifts.
// Define UREG_PARITY_EN to add a registered parity output.
module universal_register_n #(
    parameter int WIDTH = 8,
    parameter int SAT   = 0,
    parameter int AMT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    universal_register_n_if.slave bus
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [WIDTH-1:0] ONES = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic             fill_q, fill_d;

    logic [AMT_W-1:0] amt_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   cont_res;
    logic [WIDTH:0]   new_res;

    // Returns {bit shifted out, shifted value}; left=1 shifts toward MSB.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic             left,
        input logic             r,
        input logic             f
    );
        logic fb;
        if (left) begin
            fb = r ? v[WIDTH-1] : f;
            return {v[WIDTH-1], v[WIDTH-2:0], fb};
        end else begin
            fb = r ? v[0] : f;
            return {v[0], fb, v[WIDTH-1:1]};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        fill_d  = fill_q;

        amt_eff  = (bus.amt == '0) ? AMT_W'(1) : bus.amt;
        sum      = {1'b0, out_q} + (WIDTH+1)'(1);
        diff     = {1'b0, out_q} - (WIDTH+1)'(1);
        cont_res = shift_step(out_q, dir_q, rot_q, fill_q);
        new_res  = shift_step(out_q, ~bus.sr, bus.rot,
                              bus.sr ? bus.ir : bus.il);

        case (state_q)
            IDLE: begin
                if (bus.cl) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                end else if (bus.ld) begin
                    out_d = bus.in;
                end else if (bus.inc) begin
                    if (SAT != 0 && out_q == ONES) begin
                        carry_d = 1'b1;
                    end else begin
                        {carry_d, out_d} = sum;
                    end
                end else if (bus.dec) begin
                    if (SAT != 0 && out_q == '0) begin
                        carry_d = 1'b1;
                    end else begin
                        {carry_d, out_d} = diff;
                    end
                end else if (bus.sr || bus.sl) begin
                    {carry_d, out_d} = new_res;
                    if (amt_eff > AMT_W'(1)) begin
                        state_d = SHIFT;
                        cnt_d   = amt_eff - AMT_W'(1);
                        dir_d   = ~bus.sr;
                        rot_d   = bus.rot;
                        fill_d  = bus.sr ? bus.ir : bus.il;
                    end
                end
            end
            SHIFT: begin
                // Only clear can interrupt a shift in flight.
                if (bus.cl) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    {carry_d, out_d} = cont_res;
                    cnt_d = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            fill_q  <= fill_d;
        end
    end

`ifdef UREG_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^out_d;
        end
    end

    assign bus.parity = par_q;
`endif

    assign bus.out   = out_q;
    assign bus.busy  = (state_q == SHIFT);
    assign bus.carry = carry_q;
    assign bus.zero  = (out_q == '0);

endmodule

// File: tb/tb_universal_register_n.sv
// Directed scoreboard bench for universal_register_n (SAT=0 and SAT=1 instances).
// Parity is also checked when built with UREG_PARITY_EN.
module tb_universal_register_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    universal_register_n_if #(.WIDTH(8), .AMT_W(4)) b0 ();
    universal_register_n_if #(.WIDTH(8), .AMT_W(3)) b1 ();

    universal_register_n #(.WIDTH(8), .SAT(0), .AMT_W(4)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    universal_register_n #(.WIDTH(8), .SAT(1), .AMT_W(3)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    typedef struct {
        string      tag;
        bit         sel;
        logic [7:0] out;
        logic       busy;
        logic       carry;
    } exp_t;

    exp_t sbq[$];
    int   n_run  = 0;
    int   n_fail = 0;

    logic [7:0] m_out;
    logic       m_carry;

    task automatic idle_in();
        b0.cl = 0; b0.ld = 0; b0.in = '0; b0.inc = 0; b0.dec = 0;
        b0.sr = 0; b0.sl = 0; b0.ir = 0; b0.il = 0; b0.rot = 0;
        b0.amt = '0;
        b1.cl = 0; b1.ld = 0; b1.in = '0; b1.inc = 0; b1.dec = 0;
        b1.sr = 0; b1.sl = 0; b1.ir = 0; b1.il = 0; b1.rot = 0;
        b1.amt = '0;
    endtask

    task automatic cmd(input bit sel, input logic cl, input logic ld,
                       input logic [7:0] din, input logic inc,
                       input logic dec, input logic sr, input logic sl,
                       input logic fb, input logic rot,
                       input logic [3:0] amt);
        if (sel == 1'b0) begin
            b0.cl = cl; b0.ld = ld; b0.in = din; b0.inc = inc;
            b0.dec = dec; b0.sr = sr; b0.sl = sl; b0.ir = fb;
            b0.il = fb; b0.rot = rot; b0.amt = amt;
        end else begin
            b1.cl = cl; b1.ld = ld; b1.in = din; b1.inc = inc;
            b1.dec = dec; b1.sr = sr; b1.sl = sl; b1.ir = fb;
            b1.il = fb; b1.rot = rot; b1.amt = amt[2:0];
        end
    endtask

    task automatic push(input string tag, input bit sel,
                        input logic [7:0] eo, input logic eb,
                        input logic ec);
        exp_t e;
        e.tag = tag; e.sel = sel; e.out = eo; e.busy = eb; e.carry = ec;
        sbq.push_back(e);
    endtask

    task automatic cmp();
        exp_t       e;
        logic [7:0] ao;
        logic       ab, ac, az, ap;
        e = sbq.pop_front();
        ao = e.sel ? b1.out   : b0.out;
        ab = e.sel ? b1.busy  : b0.busy;
        ac = e.sel ? b1.carry : b0.carry;
        az = e.sel ? b1.zero  : b0.zero;
`ifdef UREG_PARITY_EN
        ap = e.sel ? b1.parity : b0.parity;
`else
        ap = ^ao;
`endif
        n_run++;
        assert (ao === e.out) else begin
            n_fail++;
            $error("FAIL %s out: got %h want %h", e.tag, ao, e.out);
        end
        n_run++;
        assert (ab === e.busy) else begin
            n_fail++;
            $error("FAIL %s busy: got %b want %b", e.tag, ab, e.busy);
        end
        n_run++;
        assert (ac === e.carry) else begin
            n_fail++;
            $error("FAIL %s carry: got %b want %b", e.tag, ac, e.carry);
        end
        n_run++;
        assert (az === (e.out == 8'h00)) else begin
            n_fail++;
            $error("FAIL %s zero: got %b want %b", e.tag, az,
                   e.out == 8'h00);
        end
`ifdef UREG_PARITY_EN
        n_run++;
        assert (ap === ^e.out) else begin
            n_fail++;
            $error("FAIL %s parity: got %b want %b", e.tag, ap, ^e.out);
        end
`endif
    endtask

    task automatic step(input string tag, input bit sel,
                        input logic [7:0] eo, input logic eb,
                        input logic ec);
        push(tag, sel, eo, eb, ec);
        @(posedge clk);
        #1;
        idle_in();
        cmp();
    endtask

    // Multi-cycle shift on u0 with distractor commands during busy.
    task automatic run_shift(input string tag, input logic left,
                             input logic rot, input logic fb,
                             input int n);
        int nn;
        nn = (n == 0) ? 1 : n;
        for (int i = 0; i < nn; i++) begin
            if (i == 0) begin
                cmd(0, 0, 0, 8'h00, 0, 0, !left, left, fb, rot, 4'(n));
            end else begin
                cmd(0, 0, 1, 8'h00, 1, 1, left, !left, !fb, !rot, 4'd2);
            end
            if (left) begin
                m_carry = m_out[7];
                m_out   = {m_out[6:0], rot ? m_out[7] : fb};
            end else begin
                m_carry = m_out[0];
                m_out   = {rot ? m_out[0] : fb, m_out[7:1]};
            end
            step(tag, 0, m_out, i < nn - 1, m_carry);
        end
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        #12;
        push("rst0", 0, 8'h00, 0, 0); cmp();
        push("rst1", 1, 8'h00, 0, 0); cmp();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cmd(0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
        step("ld_ff", 0, 8'hFF, 0, 0);
        cmd(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        step("inc_wrap", 0, 8'h00, 0, 1);
        cmd(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        step("dec_wrap", 0, 8'hFF, 0, 1);
        step("hold", 0, 8'hFF, 0, 1);
        cmd(0, 0, 1, 8'h10, 1, 1, 1, 0, 0, 0, 0);
        step("ld_prio", 0, 8'h10, 0, 1);
        cmd(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        step("inc_mid", 0, 8'h11, 0, 0);
        cmd(0, 1, 1, 8'h55, 1, 0, 0, 0, 0, 0, 0);
        step("cl_prio", 0, 8'h00, 0, 0);

        cmd(1, 0, 1, 8'hFE, 0, 0, 0, 0, 0, 0, 0);
        step("s_ld_fe", 1, 8'hFE, 0, 0);
        cmd(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        step("s_inc1", 1, 8'hFF, 0, 0);
        cmd(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        step("s_inc2", 1, 8'hFF, 0, 1);
        cmd(1, 0, 1, 8'h01, 0, 0, 0, 0, 0, 0, 0);
        step("s_ld_01", 1, 8'h01, 0, 1);
        cmd(1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        step("s_dec1", 1, 8'h00, 0, 0);
        cmd(1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        step("s_dec2", 1, 8'h00, 0, 1);

        cmd(0, 0, 1, 8'b1001_0110, 0, 0, 0, 0, 0, 0, 0);
        step("ld_96", 0, 8'h96, 0, 0);
        m_out = 8'h96; m_carry = 1'b0;
        run_shift("sr3", 0, 0, 1, 3);
        push("sr3_final", 0, 8'b1111_0010, 0, 1); cmp();

        cmd(0, 0, 1, 8'b1000_0001, 0, 0, 0, 0, 0, 0, 0);
        step("ld_81", 0, 8'h81, 0, 1);
        m_out = 8'h81;
        run_shift("rl0", 1, 1, 0, 0);
        run_shift("rl9", 1, 1, 0, 9);
        push("rl9_final", 0, 8'b0000_0110, 0, 0); cmp();

        cmd(0, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 0, 0);
        step("ld_5a", 0, 8'h5A, 0, 0);
        m_out = 8'h5A;
        run_shift("sl10", 1, 0, 1, 10);
        push("sl10_final", 0, 8'hFF, 0, 1); cmp();

        cmd(0, 0, 1, 8'hA5, 0, 0, 0, 0, 0, 0, 0);
        step("ld_a5", 0, 8'hA5, 0, 1);
        cmd(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 5);
        step("a_s1", 0, 8'h52, 1, 1);
        step("a_s2", 0, 8'h29, 1, 0);
        cmd(0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        step("abort_cl", 0, 8'h00, 0, 0);
        step("after_cl", 0, 8'h00, 0, 0);

        cmd(0, 0, 1, 8'hA5, 0, 0, 0, 0, 0, 0, 0);
        step("ld_a5b", 0, 8'hA5, 0, 0);
        cmd(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 5);
        step("r_s1", 0, 8'h52, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        push("rst_mid", 0, 8'h00, 0, 0); cmp();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("after_rst", 0, 8'h00, 0, 0);

        cmd(0, 0, 1, 8'h07, 0, 0, 0, 0, 0, 0, 0);
        step("p_ld07", 0, 8'h07, 0, 0);
        cmd(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        step("p_inc08", 0, 8'h08, 0, 0);
        cmd(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        step("p_inc09", 0, 8'h09, 0, 0);

        n_run++;
        assert (sbq.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_empty: got %0d want 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
